// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// The configuration word width is fixed here; the top's CNT_WIDTH is expected to match DIV_W.
package clock_divider_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DIV_W = 24;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             mode;
  } cfg_t;

  function automatic int ch_index_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: wrap counter, active/shadow configuration and registered outputs.
// A shadow write is only copied into the active config at a wrap or while disabled.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEFAULT_DIV  = 124999,
  parameter logic             DEFAULT_MODE = MODE_TOGGLE
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic sync,
  input  logic write,
  input  cfg_t cfg_in,
  output logic slow_clock,
  output logic tick,
  output logic pending
);

  localparam cfg_t RESET_CFG = '{div: DEFAULT_DIV, mode: DEFAULT_MODE};

  cfg_t             active;
  cfg_t             shadow;
  logic [DIV_W-1:0] count;
  logic             wrap;

  assign wrap = (count == active.div);

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      active     <= RESET_CFG;
      shadow     <= RESET_CFG;
      pending    <= 1'b0;
      slow_clock <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (sync) begin
        // sync beats a wrap and never applies a pending write
        count      <= '0;
        slow_clock <= 1'b0;
        tick       <= 1'b0;
      end else if (!enable) begin
        count      <= '0;
        slow_clock <= 1'b0;
        tick       <= 1'b0;
        if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (wrap) begin
        count <= '0;
        tick  <= 1'b1;
        if (pending) begin
          active     <= shadow;
          pending    <= 1'b0;
          slow_clock <= 1'b0;
        end else begin
          slow_clock <= (active.mode == MODE_PULSE) ? 1'b1 : ~slow_clock;
        end
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
        if (active.mode == MODE_PULSE) slow_clock <= 1'b0;
      end
      // write is only possible while nothing is pending, so it never collides with an apply
      if (write) begin
        shadow  <= cfg_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: write decode, ready mux and channel array.
// Handshake: a write transfers when cfg_valid && cfg_ready; cfg_ready for cfg_ch is low while that channel still holds an unapplied write.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int                   NUM_CH       = 4,
  parameter int                   CNT_WIDTH    = DIV_W,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV  = 124999,
  parameter logic                 DEFAULT_MODE = MODE_TOGGLE
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CH-1:0]                     enable,
  input  logic                                  sync,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [ch_index_width(NUM_CH)-1:0]     cfg_ch,
  input  logic [CNT_WIDTH-1:0]                  cfg_div,
  input  logic                                  cfg_mode,
  output logic [NUM_CH-1:0]                     slow_clock,
  output logic [NUM_CH-1:0]                     tick
);

  localparam int CH_W = ch_index_width(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] write;
  cfg_t              cfg_word;

  assign cfg_word  = '{div: cfg_div, mode: cfg_mode};
  assign cfg_ready = ~pending[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign write[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clock_divider_channel #(
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable[i]),
      .sync       (sync),
      .write      (write[i]),
      .cfg_in     (cfg_word),
      .slow_clock (slow_clock[i]),
      .tick       (tick[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed scenarios followed by random traffic,
// compared against an epoch/age based reference model.
module tb_clock_divider_multi;

  localparam int NUM_CH   = 4;
  localparam int CW       = 24;
  localparam int DEF_DIV  = 124999;
  localparam bit DEF_MODE = 1'b0;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] enable;
  logic              sync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CW-1:0]     cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] slow_clock;
  logic [NUM_CH-1:0] tick;

  clock_divider_multi dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sync       (sync),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .slow_clock (slow_clock),
    .tick       (tick)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: each channel counts edges since its current epoch started
  int        age   [NUM_CH];
  int        wraps [NUM_CH];
  int        div_m [NUM_CH];
  bit        mode_m[NUM_CH];
  int        sdiv  [NUM_CH];
  bit        smode [NUM_CH];
  bit        pend  [NUM_CH];
  logic [7:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      age[c] = 0; wraps[c] = 0; div_m[c] = DEF_DIV; mode_m[c] = DEF_MODE;
      sdiv[c] = DEF_DIV; smode[c] = DEF_MODE; pend[c] = 0;
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] en, input bit s,
                            input bit acc, input int ch, input int d, input bit m);
    logic [3:0] es, et;
    bit w;
    es = '0; et = '0;
    if (r) begin
      model_reset();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (s || !en[c]) begin
          age[c] = 0; wraps[c] = 0;
          if (!s && pend[c]) begin
            div_m[c] = sdiv[c]; mode_m[c] = smode[c]; pend[c] = 0;
          end
        end else begin
          age[c]++;
          w = (age[c] % (div_m[c] + 1)) == 0;
          et[c] = w;
          if (w && pend[c]) begin
            div_m[c] = sdiv[c]; mode_m[c] = smode[c]; pend[c] = 0;
            age[c] = 0; wraps[c] = 0; es[c] = 1'b0;
          end else begin
            if (w) wraps[c]++;
            es[c] = mode_m[c] ? w : wraps[c][0];
          end
        end
      end
      if (acc) begin
        sdiv[ch] = d; smode[ch] = m; pend[ch] = 1;
      end
    end
    exp_q.push_back({es, et});
  endtask

  // driver: one full clock cycle with checks of ready and outputs
  task automatic step(input bit r, input logic [3:0] en, input bit s, input bit v,
                      input int ch, input int d, input bit m);
    bit acc;
    logic [7:0] e;
    @(negedge clock);
    reset = r; enable = en; sync = s; cfg_valid = v;
    cfg_ch = ch[1:0]; cfg_div = d[CW-1:0]; cfg_mode = m;
    #1;
    check("cfg_ready", {31'b0, cfg_ready}, {31'b0, !pend[ch]});
    acc = v && !pend[ch] && !r;
    @(posedge clock);
    model_edge(r, en, s, acc, ch, d, m);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("slow_clock", {28'b0, slow_clock}, {28'b0, e[7:4]});
      check("tick",       {28'b0, tick},       {28'b0, e[3:0]});
    end
  endtask

  task automatic idle(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] en_r;
    reset = 1'b1; enable = '0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    #1;
    check("reset_slow", {28'b0, slow_clock}, 32'd0);
    check("reset_tick", {28'b0, tick}, 32'd0);
    check("reset_ready", {31'b0, cfg_ready}, 32'd1);

    // program all channels while disabled (applied on the next edge)
    step(0, 4'h0, 0, 1, 0, 3, 0);
    step(0, 4'h0, 0, 1, 1, 5, 0);
    step(0, 4'h0, 0, 1, 2, 0, 0);
    step(0, 4'h0, 0, 1, 3, 2, 1);
    step(0, 4'h0, 0, 0, 0, 0, 0);

    // D=3 toggle: ticks at 4, 8, 12; slow rises at 4 and falls at 8
    for (int k = 1; k <= 12; k++) begin
      step(0, 4'hF, 0, 0, 0, 0, 0);
      check("p1_tick0", {31'b0, tick[0]}, {31'b0, (k % 4) == 0});
      check("p1_slow0", {31'b0, slow_clock[0]}, {31'b0, ((k / 4) % 2) == 1});
    end

    // pulse D=2 on ch1 while it runs at D=5
    step(0, 4'hF, 0, 1, 1, 2, 1);
    for (int i = 0; i < 18; i++) step(0, 4'hF, 0, 0, 1, 0, 0);

    // back-to-back writes to ch0, second held off; ch2 still accepts
    step(0, 4'hF, 0, 1, 0, 1, 0);
    step(0, 4'hF, 0, 1, 0, 2, 0);
    step(0, 4'hF, 0, 1, 2, 4, 0);
    idle(10, 4'hF);

    // D=0 toggle on ch3, then disable it
    step(0, 4'hF, 0, 1, 3, 0, 0);
    idle(8, 4'hF);
    idle(3, 4'h7);
    idle(4, 4'hF);

    // sync at an arbitrary cycle
    step(0, 4'hF, 0, 1, 0, 3, 0);
    step(0, 4'hF, 0, 1, 1, 5, 0);
    idle(9, 4'hF);
    step(0, 4'hF, 1, 0, 0, 0, 0);
    idle(12, 4'hF);

    // reset mid-period with a pending write
    step(0, 4'hF, 0, 1, 0, 6, 1);
    step(1, 4'hF, 0, 0, 0, 0, 0);
    idle(30, 4'hF);
    idle(1, 4'h0);
    idle(20, 4'hF);

    // random traffic
    en_r = 4'h0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 19) == 0) en_r[c] = ~en_r[c];
      step($urandom_range(0, 399) == 0, en_r, $urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
